spm_param_mult: RTL and testbench

SPM_PARAM_MULT -- requirements
Module: spm_param_mult

---
 rtl/spm_pkg.sv | 19 +
 rtl/spm_csa_array.sv | 43 ++++
 rtl/spm_param_mult.sv | 87 ++++++++
 tb/tb_spm_param_mult.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier.
// Holds the FSM state encoding and the counter-width function.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, at least 1 so a counter is never zero bits wide.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spm_csa_array.sv
// Carry-save serial-parallel array: x is parallel, ybit arrives LSB first,
// and one product bit leaves on p every enabled cycle.
module spm_csa_array
    import spm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic             ybit,
    input  logic             tc,
    output logic             p
);

    logic [WIDTH-1:0] s_q, c_q, s_d, c_d;
    logic [WIDTH-1:0] pp, t, k;

    // s+c+pp == t+2k holds exactly in both signed and unsigned readings, so
    // halving t (arithmetic shift when tc) keeps the running sum exact.
    always_comb begin
        pp  = x & {WIDTH{ybit}};
        t   = s_q ^ c_q ^ pp;
        k   = (s_q & c_q) | (s_q & pp) | (c_q & pp);
        s_d = {tc & t[WIDTH-1], t[WIDTH-1:1]};
        c_d = k;
    end

    assign p = t[0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s_q <= '0;
            c_q <= '0;
        end else if (en) begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/spm_param_mult.sv
// Parameterised serial-parallel multiplier: FSM, counter, operand registers
// and product shift register around the carry-save array.
module spm_param_mult
    import spm_pkg::*;
#(
    parameter int   WIDTH      = 32,
    parameter logic SIGNED_DEF = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tc,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic [2*WIDTH-1:0] prod,
    output logic               done,
    output logic               busy
);

    localparam int CW = clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mc_q, mp_q;
    logic               tc_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               capture, step, pbit;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MULT;
            MULT:    if (!start) state_d = IDLE;
                     else if (cnt_q == LAST) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == MULT);
        done    = (state_q == DONE);
        capture = (state_q == IDLE) && start;
        step    = (state_q == MULT) && start;
    end

    // The multiplier shifts right with sign fill, so after WIDTH steps it
    // supplies the sign-extension bits by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            tc_q   <= SIGNED_DEF;
            prod_q <= '0;
        end else if (capture) begin
            cnt_q <= '0;
            mc_q  <= mc;
            mp_q  <= mp;
            tc_q  <= tc;
        end else if (step) begin
            cnt_q  <= cnt_q + CW'(1);
            mp_q   <= {tc_q & mp_q[WIDTH-1], mp_q[WIDTH-1:1]};
            prod_q <= {pbit, prod_q[2*WIDTH-1:1]};
        end
    end

    spm_csa_array #(.WIDTH(WIDTH)) u_array (
        .clk  (clk),
        .rst  (rst),
        .clr  (capture),
        .en   (step),
        .x    (mc_q),
        .ybit (mp_q[0]),
        .tc   (tc_q),
        .p    (pbit)
    );

    assign prod = prod_q;

endmodule

// File: tb/tb_spm_param_mult.sv
// Self-checking bench for spm_param_mult at WIDTH=32 and WIDTH=8 against an
// arithmetic product model.
module tb_spm_param_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, tc = 1'b1;
    logic [31:0] mc = '0, mp = '0;
    logic [63:0] prod;
    logic        done, busy;
    logic        start8 = 1'b0, tc8 = 1'b1;
    logic [7:0]  mc8 = '0, mp8 = '0;
    logic [15:0] prod8;
    logic        done8, busy8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spm_param_mult #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .tc(tc), .mc(mc), .mp(mp),
        .prod(prod), .done(done), .busy(busy)
    );

    spm_param_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .tc(tc8), .mc(mc8), .mp(mp8),
        .prod(prod8), .done(done8), .busy(busy8)
    );

    function automatic logic [63:0] model32(input logic t, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (t) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] model8(input logic t, input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        if (t) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 16'(sa * sb);
        end
        return {8'b0, a} * {8'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic t, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit tog, input string nm);
        int n, nb;
        bit both;
        logic [63:0] held;
        tc = t; mc = a; mp = b; start = 1'b1;
        n = 0; nb = 0; both = 0;
        do begin
            tick();
            n++;
            if (busy) nb++;
            if (busy && done) both = 1;
            if (tog && busy) begin mc = $urandom; mp = $urandom; tc = 1'($urandom); end
        end while (!done && n < 200);
        total++; if (n !== 65) begin bad++; $display("FAIL %s latency got=%0d want=65", nm, n); end
        total++; if (nb !== 64) begin bad++; $display("FAIL %s busy_cycles got=%0d want=64", nm, nb); end
        total++; if (both) begin bad++; $display("FAIL %s busy_and_done got=1 want=0", nm); end
        total++; if (prod !== exp) begin bad++; $display("FAIL %s prod got=%h want=%h", nm, prod, exp); end
        held = exp;
        if (tog) begin mc = $urandom; mp = $urandom; tc = 1'($urandom); end
        repeat (3) tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || prod !== held) begin
            bad++; $display("FAIL %s hold done=%b busy=%b prod=%h want done=1 busy=0 prod=%h", nm, done, busy, prod, held);
        end
        start = 1'b0;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s release done=%b busy=%b want 0 0", nm, done, busy);
        end
    endtask

    task automatic do_op8(input logic t, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string nm);
        int n, nb;
        tc8 = t; mc8 = a; mp8 = b; start8 = 1'b1;
        n = 0; nb = 0;
        do begin
            tick();
            n++;
            if (busy8) nb++;
        end while (!done8 && n < 100);
        total++; if (n !== 17) begin bad++; $display("FAIL %s latency got=%0d want=17", nm, n); end
        total++; if (nb !== 16) begin bad++; $display("FAIL %s busy_cycles got=%0d want=16", nm, nb); end
        total++; if (prod8 !== exp) begin bad++; $display("FAIL %s prod got=%h want=%h", nm, prod8, exp); end
        start8 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start8 = 1'b1;
        repeat (2) tick();
        total++;
        if (prod !== 64'd0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset32 prod=%h done=%b busy=%b want 0", prod, done, busy);
        end
        total++;
        if (prod8 !== 16'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++; $display("FAIL reset8 prod=%h done=%b busy=%b want 0", prod8, done8, busy8);
        end
        start = 1'b0; start8 = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        do_op(1'b1, 32'd3, 32'd4, 64'd12, 0, "small");
        do_op(1'b1, -32'sd15, 32'd10, -64'sd150, 0, "neg_pos");
        do_op(1'b1, -32'sd159, -32'sd129, 64'd20511, 0, "neg_neg");
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, "ones_signed");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "ones_unsigned");
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, "minint");
    endtask

    task automatic test_random();
        logic t;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            t = 1'($urandom); a = $urandom; b = $urandom;
            do_op(t, a, b, model32(t, a, b), (i % 2) == 1, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        tc = 1'b1; mc = 32'd1234; mp = 32'd5678; start = 1'b1;
        tick();
        repeat (20) tick();
        start = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_idle busy=%b done=%b want 0 0", busy, done);
        end
        saw_done = 0;
        repeat (5) begin tick(); if (done) saw_done = 1; end
        total++; if (saw_done) begin bad++; $display("FAIL abort_done got=1 want=0"); end
        do_op(1'b1, 32'd6, 32'd6, 64'd36, 0, "after_abort");
    endtask

    task automatic test_rst_mid();
        int n;
        tc = 1'b1; mc = -32'sd77; mp = 32'd9001; start = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        total++;
        if (prod !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mult prod=%h busy=%b done=%b want 0", prod, busy, done);
        end
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_restart busy=%b want=1", busy); end
        n = 1;
        while (!done && n < 200) begin tick(); n++; end
        total++;
        if (prod !== model32(1'b1, -32'sd77, 32'd9001)) begin
            bad++; $display("FAIL rst_result prod=%h want=%h", prod, model32(1'b1, -32'sd77, 32'd9001));
        end
        rst = 1'b1;
        tick();
        total++;
        if (prod !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_done prod=%h busy=%b done=%b want 0", prod, busy, done);
        end
        rst = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_w8();
        logic t;
        logic [7:0] a, b;
        do_op8(1'b1, 8'h80, 8'h80, 16'd16384, "w8_minint");
        do_op8(1'b0, 8'hFF, 8'hFF, 16'd65025, "w8_unsigned");
        for (int i = 0; i < 6; i++) begin
            t = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            do_op8(t, a, b, model8(t, a, b), $sformatf("w8_rand%0d", i));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_rst_mid();
        test_w8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
